// File: rtl/q_mqcr_pkg.sv
// Shared types and widths for the qcR window streamer.
package q_mqcr_pkg;

  localparam int unsigned FEATURE_MAP_RESOLUTION = 8;
  localparam int unsigned FEATURE_MAP_ADDRWIDE   = 10;

  typedef logic signed [FEATURE_MAP_RESOLUTION-1:0]   feat_t;
  typedef logic signed [2*FEATURE_MAP_RESOLUTION-1:0] acc_t;
  typedef logic        [FEATURE_MAP_ADDRWIDE-1:0]     addr_t;

  typedef enum logic [1:0] {IDLE, STREAM, MAX, DONE} state_e;

  localparam feat_t FEAT_MAX = feat_t'({1'b0, {(FEATURE_MAP_RESOLUTION-1){1'b1}}});
  localparam feat_t FEAT_MIN = feat_t'({1'b1, {(FEATURE_MAP_RESOLUTION-1){1'b0}}});

endpackage

// File: rtl/q_mqcr_sat.sv
// Combinational requantiser: arithmetic right shift then signed saturation to feature width.
module q_mqcr_sat
  import q_mqcr_pkg::*;
#(
  parameter int unsigned QUANT_SHIFT = 8
) (
  input  logic signed [2*FEATURE_MAP_RESOLUTION-1:0] x,
  output logic signed [FEATURE_MAP_RESOLUTION-1:0]   q_c
);

  localparam acc_t HI = acc_t'(FEAT_MAX);
  localparam acc_t LO = acc_t'(FEAT_MIN);

  acc_t shifted;

  always_comb begin
    shifted = x >>> QUANT_SHIFT;
    if (shifted > HI)      q_c = FEAT_MAX;
    else if (shifted < LO) q_c = FEAT_MIN;
    else                   q_c = feat_t'(shifted);
  end

endmodule

// File: rtl/q_mqcr_rec.sv
// Streams an F_IN_H x F_IN_W window of acc_qcR as requantised beats with a per-row max trailer.
// Optional READY_BACKPRESSURE_EN enables valid/ready flow control; default streams one beat per clock.
module q_mqcr_rec
  import q_mqcr_pkg::*;
#(
  parameter int unsigned NUM_CAR_CHANNELS = 35,
  parameter int unsigned F_IN_H           = 13,
  parameter int unsigned F_IN_W           = 29,
  parameter int unsigned START_ROW        = 0,
  parameter int unsigned QUANT_SHIFT      = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_CAR_CHANNELS-1:0][NUM_CAR_CHANNELS-1:0][2*FEATURE_MAP_RESOLUTION-1:0] acc_qcR_data_i,
  input  logic [NUM_CAR_CHANNELS-1:0][NUM_CAR_CHANNELS-1:0] acc_qcR_valid_i,
  output logic                                   mqcRec_valid_o,
  output logic [FEATURE_MAP_RESOLUTION-1:0]      mqcRec_data_o,
  output logic [FEATURE_MAP_ADDRWIDE-1:0]        mqcRec_addr_o,
  input  logic                                   mqcRec_ready_i
);

  localparam int unsigned ROW_W = $clog2(NUM_CAR_CHANNELS);
  localparam int unsigned R_W   = (F_IN_H > 1) ? $clog2(F_IN_H) : 1;
  localparam int unsigned C_W   = $clog2(F_IN_W + 1);
  localparam int unsigned BEATS = F_IN_H * (F_IN_W + 1);
  localparam logic [R_W-1:0] R_LAST = R_W'(F_IN_H - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(F_IN_W - 1);

  if (START_ROW + F_IN_H > NUM_CAR_CHANNELS) begin : g_bad_rows
    $error("q_mqcr_rec: window rows exceed matrix");
  end
  if (F_IN_W > NUM_CAR_CHANNELS) begin : g_bad_cols
    $error("q_mqcr_rec: window columns exceed matrix");
  end
  if (BEATS > 2**FEATURE_MAP_ADDRWIDE) begin : g_bad_addr
    $error("q_mqcr_rec: frame does not fit address width");
  end

  state_e         state_q, state_d;
  logic [R_W-1:0] r_q, r_d;
  logic [C_W-1:0] c_q, c_d;
  feat_t          max_q, max_d;
  logic           valid_q, valid_d;
  feat_t          data_q, data_d;
  addr_t          addr_q, addr_d;

  logic             advance;
  logic             start;
  logic [ROW_W-1:0] row_sel;
  logic [ROW_W-1:0] col_sel;
  acc_t             elem;
  feat_t            q_c;
  addr_t            row_base;
  logic             unused_ok;

`ifdef READY_BACKPRESSURE_EN
  assign advance = !valid_q || mqcRec_ready_i;
`else
  assign advance = 1'b1;
`endif

  assign start     = acc_qcR_valid_i[0][0];
  assign unused_ok = ^{acc_qcR_valid_i, mqcRec_ready_i};
  assign row_sel   = ROW_W'(START_ROW) + ROW_W'(r_q);
  assign col_sel   = ROW_W'(c_q);
  assign elem      = acc_t'(acc_qcR_data_i[row_sel][col_sel]);
  assign row_base  = addr_t'(32'(r_q) * (F_IN_W + 1));

  q_mqcr_sat #(.QUANT_SHIFT(QUANT_SHIFT)) u_sat (
    .x   (elem),
    .q_c (q_c)
  );

  // Next-state and registered-output logic; everything except IDLE/DONE exits waits on advance.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    max_d   = max_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (advance) valid_d = 1'b0;
        if (start) begin
          state_d = STREAM;
          r_d     = '0;
          c_d     = '0;
        end
      end
      STREAM: begin
        if (advance) begin
          valid_d = 1'b1;
          data_d  = q_c;
          addr_d  = row_base + addr_t'(c_q);
          if (q_c > max_q) max_d = q_c;
          if (c_q == C_LAST) state_d = MAX;
          else               c_d = c_q + C_W'(1);
        end
      end
      MAX: begin
        if (advance) begin
          valid_d = 1'b1;
          data_d  = max_q;
          addr_d  = row_base + addr_t'(F_IN_W);
          max_d   = FEAT_MIN;
          if (r_q == R_LAST) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
            r_d     = r_q + R_W'(1);
            c_d     = '0;
          end
        end
      end
      DONE: begin
        if (advance) valid_d = 1'b0;
        if (!start)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      max_q   <= FEAT_MIN;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      max_q   <= max_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign mqcRec_valid_o = valid_q;
  assign mqcRec_data_o  = data_q;
  assign mqcRec_addr_o  = addr_q;

endmodule

// File: tb/tb_q_mqcr_rec.sv
// Scoreboard bench for q_mqcr_rec: reference frames are built from the matrix and checked beat by beat.
module clk_rst_gen #(
  parameter int unsigned CLK_PERIOD     = 10,
  parameter int unsigned RST_CLK_CYCLES = 4
) (
  output logic clk,
  output logic rst
);
  initial begin
    clk = 1'b0;
    forever #(CLK_PERIOD / 2) clk = ~clk;
  end
  initial begin
    rst = 1'b1;
    repeat (RST_CLK_CYCLES) @(posedge clk);
    #1 rst = 1'b0;
  end
endmodule

module tb_q_mqcr_rec;
  import q_mqcr_pkg::*;

  localparam int N     = 35;
  localparam int H     = 13;
  localparam int W     = 29;
  localparam int SR    = 6;
  localparam int SH    = 8;
  localparam int BEATS = H * (W + 1);

  typedef struct {
    int addr;
    int data;
  } beat_t;

  logic clk, gen_rst, tb_rst, rst;
  logic [N-1:0][N-1:0][15:0] acc_data;
  logic [N-1:0][N-1:0]       acc_valid;
  logic                      ready;
  logic                      out_valid;
  logic [7:0]                out_data;
  logic [9:0]                out_addr;

  int    m [N][N];
  beat_t exp_q [$];
  int    n_checks;
  int    n_fail;

  assign rst = gen_rst | tb_rst;

  clk_rst_gen #(.CLK_PERIOD(10), .RST_CLK_CYCLES(4)) u_gen (.clk(clk), .rst(gen_rst));

  q_mqcr_rec #(
    .NUM_CAR_CHANNELS(N), .F_IN_H(H), .F_IN_W(W), .START_ROW(SR), .QUANT_SHIFT(SH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .acc_qcR_data_i  (acc_data),
    .acc_qcR_valid_i (acc_valid),
    .mqcRec_valid_o  (out_valid),
    .mqcRec_data_o   (out_data),
    .mqcRec_addr_o   (out_addr),
    .mqcRec_ready_i  (ready)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // floor(x / 2^SH) then clamp to the signed 8-bit range
  function automatic int requant(input int x);
    int d, s;
    d = 1 << SH;
    s = (x >= 0) ? x / d : -((-x + d - 1) / d);
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic void push_frame();
    for (int r = 0; r < H; r++) begin
      int mx;
      mx = -128;
      for (int c = 0; c < W; c++) begin
        int q;
        q = requant(m[SR + r][c]);
        exp_q.push_back('{r * (W + 1) + c, q});
        if (q > mx) mx = q;
      end
      exp_q.push_back('{r * (W + 1) + W, mx});
    end
  endfunction

  task automatic apply_matrix();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        acc_data[r][c] = 16'(m[r][c]);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic wait_until(input string name, input int left, input int budget);
    for (int i = 0; i < budget && exp_q.size() > left; i++) @(posedge clk);
    if (exp_q.size() > left) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d beats outstanding, required %0d", name, exp_q.size(), left);
    end
  endtask

  task automatic idle_hold(input string name);
    repeat (40) @(negedge clk);
    check({name, "_idle_valid"}, int'(out_valid), 0);
    check({name, "_no_extra_beats"}, exp_q.size(), 0);
    @(posedge clk);
    #1 acc_valid[0][0] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_frame(input string name);
    apply_matrix();
    push_frame();
    @(posedge clk);
    #1 acc_valid[0][0] = 1'b1;
    wait_until(name, 0, 6000);
    idle_hold(name);
  endtask

  // Ready: random under backpressure, deliberately X when it must be ignored.
  initial begin
    ready = 1'bx;
    forever begin
      @(posedge clk);
      #1;
`ifdef READY_BACKPRESSURE_EN
      ready = ($urandom_range(0, 9) < 6);
`else
      ready = 1'bx;
`endif
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks hold during stalls.
  initial begin : monitor
    logic stall_pend;
    logic accepted;
    int   hold_data, hold_addr;
    stall_pend = 1'b0;
    hold_data  = 0;
    hold_addr  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", int'($signed(out_data)), hold_data);
          check("stall_addr", int'(out_addr), hold_addr);
        end
        if (out_valid) begin
`ifdef READY_BACKPRESSURE_EN
          accepted = (ready == 1'b1);
`else
          accepted = 1'b1;
`endif
          if (accepted) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_beat: addr %0d data %0d, required no beat",
                       out_addr, $signed(out_data));
            end else begin
              beat_t e;
              e = exp_q.pop_front();
              check("beat_addr", int'(out_addr), e.addr);
              check("beat_data", int'($signed(out_data)), e.data);
            end
          end
          stall_pend = !accepted;
          hold_data  = int'($signed(out_data));
          hold_addr  = int'(out_addr);
        end else begin
          stall_pend = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    tb_rst    = 1'b0;
    acc_valid = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = 0;
    apply_matrix();

    @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(out_data), 0);
    check("reset_addr", int'(out_addr), 0);
    while (gen_rst) @(posedge clk);
    repeat (2) @(posedge clk);

    // Ramp that saturates high everywhere in the window
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = ((r * 64 + c) * 256 > 32767) ? 32767 : (r * 64 + c) * 256;
    run_frame("ramp");

    // Column index ramp: rows 0..28, trailer 28
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = c * 256;
    run_frame("col_ramp");

    // Saturation corners on top of random data
    fill_random();
    m[SR][0] = 32767;
    m[SR][1] = -32768;
    m[SR][2] = -1;
    m[SR][3] = 255;
    for (int c = 0; c < W; c++) m[SR + 1][c] = -32768 + c;
    run_frame("sat");

    // Same matrix again after dropping and re-raising start
    run_frame("repeat");

    // Reset abort mid-frame, then a clean restart from address 0
    fill_random();
    apply_matrix();
    push_frame();
    @(posedge clk);
    #1 acc_valid[0][0] = 1'b1;
    wait_until("pre_abort", BEATS - 100, 6000);
    @(posedge clk);
    #1;
    tb_rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    push_frame();
    @(negedge clk);
    check("abort_valid", int'(out_valid), 0);
    wait_until("post_abort", 0, 6000);
    idle_hold("post_abort");

    // Random frames
    for (int k = 0; k < 2; k++) begin
      fill_random();
      run_frame("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
